// File: rtl/wram_access_arbiter_pkg.sv
// Shared constants and types for the working-RAM access arbiter.
// Address map, echo folding offset and arbiter FSM encoding.
package wram_access_arbiter_pkg;

    localparam logic [15:0] WRAM_BASE   = 16'hC000;
    localparam logic [15:0] WRAM_END    = 16'hDFFF;
    localparam logic [15:0] ECHO_BASE   = 16'hE000;
    localparam logic [15:0] ECHO_END    = 16'hFDFF;
    localparam logic [15:0] ECHO_OFFSET = 16'h2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    function automatic logic [15:0] fold_echo(input logic [15:0] a);
        return a - ECHO_OFFSET;
    endfunction

endpackage

// File: rtl/wram_access_arbiter_if.sv
// Requester, bank and status signals of the working-RAM arbiter.
// The arbiter takes the slave view; bench/requesters take master.
interface wram_access_arbiter_if;

    logic        I_CPU_REQ;
    logic        I_CPU_WE;
    logic [15:0] I_CPU_ADDR;
    logic [7:0]  I_CPU_WDATA;
    logic [7:0]  O_CPU_RDATA;
    logic        O_CPU_ACK;

    logic        I_DMA_REQ;
    logic        I_DMA_WE;
    logic [15:0] I_DMA_ADDR;
    logic [7:0]  I_DMA_WDATA;
    logic [7:0]  O_DMA_RDATA;
    logic        O_DMA_ACK;
    logic        I_DMA_LOCK;

    logic [15:0] O_WRAM_ADDR;
    logic [7:0]  O_WRAM_WDATA;
    logic        O_WRAM_WE_L;
    logic        O_WRAM_RE_L;
    logic [7:0]  I_WRAM_RDATA;

    logic        O_GRANT_DMA;
    logic        O_OOB_ERR;

    modport slave (
        input  I_CPU_REQ, I_CPU_WE, I_CPU_ADDR, I_CPU_WDATA,
        input  I_DMA_REQ, I_DMA_WE, I_DMA_ADDR, I_DMA_WDATA, I_DMA_LOCK,
        input  I_WRAM_RDATA,
        output O_CPU_RDATA, O_CPU_ACK, O_DMA_RDATA, O_DMA_ACK,
        output O_WRAM_ADDR, O_WRAM_WDATA, O_WRAM_WE_L, O_WRAM_RE_L,
        output O_GRANT_DMA, O_OOB_ERR
    );

    modport master (
        output I_CPU_REQ, I_CPU_WE, I_CPU_ADDR, I_CPU_WDATA,
        output I_DMA_REQ, I_DMA_WE, I_DMA_ADDR, I_DMA_WDATA, I_DMA_LOCK,
        output I_WRAM_RDATA,
        input  O_CPU_RDATA, O_CPU_ACK, O_DMA_RDATA, O_DMA_ACK,
        input  O_WRAM_ADDR, O_WRAM_WDATA, O_WRAM_WE_L, O_WRAM_RE_L,
        input  O_GRANT_DMA, O_OOB_ERR
    );

endinterface

// File: rtl/wram_addr_fold.sv
// Combinational working-RAM decode: range check and echo-RAM folding.
// Out-of-range addresses pass through unchanged with in_range_o low.
module wram_addr_fold
    import wram_access_arbiter_pkg::*;
(
    input  logic [15:0] addr_i,
    output logic        in_range_o,
    output logic [15:0] addr_o
);

    always_comb begin
        in_range_o = 1'b0;
        addr_o     = addr_i;
        unique case (1'b1)
            (addr_i >= WRAM_BASE && addr_i <= WRAM_END): begin
                in_range_o = 1'b1;
            end
            (addr_i >= ECHO_BASE && addr_i <= ECHO_END): begin
                in_range_o = 1'b1;
                addr_o     = fold_echo(addr_i);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wram_access_arbiter.sv
// Shares the working-RAM port between CPU and DMA as 2-cycle ISSUE/DONE
// transactions; DMA has priority, bounded by a CPU-starvation run counter.
module wram_access_arbiter
    import wram_access_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DMA_RUN = 4,
    parameter logic [7:0]  OOB_DATA    = 8'hFF
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET_L,
    wram_access_arbiter_if.slave       bus
);

    localparam logic [3:0] MAX_RUN = 4'(MAX_DMA_RUN);

    arb_state_e  state_q, state_d;
    logic        grant_dma_q, grant_dma_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        oob_q, oob_d;
    logic [3:0]  run_q, run_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;

    logic        cpu_win, dma_win, just_acked, grant;
    logic        issue, done, cpu_ack, dma_ack;
    logic [15:0] req_addr, fold_addr;
    logic        in_range;
    logic [7:0]  rd_now;

    wram_addr_fold u_fold (
        .addr_i     (req_addr),
        .in_range_o (in_range),
        .addr_o     (fold_addr)
    );

    assign issue   = (state_q == ST_ISSUE);
    assign done    = (state_q == ST_DONE);
    assign cpu_ack = done && !grant_dma_q;
    assign dma_ack = done && grant_dma_q;
    assign rd_now  = oob_q ? OOB_DATA : bus.I_WRAM_RDATA;

    // Winner is picked on raw REQs; if it is the one just ACKed we idle a
    // cycle instead of handing the slot to the loser out of turn.
    assign cpu_win = bus.I_CPU_REQ && !bus.I_DMA_LOCK
                     && (!bus.I_DMA_REQ || run_q == MAX_RUN);
    assign dma_win = bus.I_DMA_REQ && !cpu_win;
    assign just_acked = done && ((grant_dma_q && dma_win)
                                 || (!grant_dma_q && cpu_win));
    assign grant = (state_q == ST_IDLE || done)
                   && (cpu_win || dma_win) && !just_acked;
    assign req_addr = dma_win ? bus.I_DMA_ADDR : bus.I_CPU_ADDR;

    always_comb begin
        state_d     = state_q;
        grant_dma_d = grant_dma_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        oob_d       = oob_q;
        run_d       = run_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        unique case (state_q)
            ST_IDLE:  state_d = grant ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_DONE;
            ST_DONE:  state_d = grant ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (cpu_ack && !we_q) cpu_rdata_d = rd_now;
        if (dma_ack && !we_q) dma_rdata_d = rd_now;

        if (grant) begin
            grant_dma_d = dma_win;
            addr_d      = fold_addr;
            oob_d       = !in_range;
            we_d        = dma_win ? bus.I_DMA_WE : bus.I_CPU_WE;
            wdata_d     = dma_win ? bus.I_DMA_WDATA : bus.I_CPU_WDATA;
        end

        if (!bus.I_CPU_REQ || (grant && cpu_win)) begin
            run_d = 4'd0;
        end else if (grant && dma_win && !bus.I_DMA_LOCK && run_q < MAX_RUN) begin
            run_d = run_q + 4'd1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state_q     <= ST_IDLE;
            grant_dma_q <= 1'b0;
            addr_q      <= 16'h0000;
            we_q        <= 1'b0;
            wdata_q     <= 8'h00;
            oob_q       <= 1'b0;
            run_q       <= 4'd0;
            cpu_rdata_q <= OOB_DATA;
            dma_rdata_q <= OOB_DATA;
        end else begin
            state_q     <= state_d;
            grant_dma_q <= grant_dma_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            oob_q       <= oob_d;
            run_q       <= run_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign bus.O_WRAM_ADDR  = addr_q;
    assign bus.O_WRAM_WDATA = wdata_q;
    assign bus.O_WRAM_RE_L  = !(issue && !we_q && !oob_q);
    assign bus.O_WRAM_WE_L  = !(issue && we_q && !oob_q);
    assign bus.O_CPU_ACK    = cpu_ack;
    assign bus.O_DMA_ACK    = dma_ack;
    assign bus.O_CPU_RDATA  = (cpu_ack && !we_q) ? rd_now : cpu_rdata_q;
    assign bus.O_DMA_RDATA  = (dma_ack && !we_q) ? rd_now : dma_rdata_q;
    assign bus.O_GRANT_DMA  = grant_dma_q;
    assign bus.O_OOB_ERR    = done && oob_q;

endmodule

// File: tb/tb_wram_access_arbiter.sv
// Directed bench for wram_access_arbiter: CPU vector table plus
// DMA arbitration, lock and mid-transaction reset sequences.
module tb_wram_access_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wram_access_arbiter_if bus ();

    wram_access_arbiter #(.MAX_DMA_RUN(4), .OOB_DATA(8'hFF)) dut (
        .I_CLK     (clk),
        .I_RESET_L (rst_n),
        .bus       (bus)
    );

    logic [7:0] mem [0:8191];
    logic [7:0] bank_rdata = 8'h00;

    always @(posedge clk) begin
        if (!bus.O_WRAM_RE_L) bank_rdata <= mem[bus.O_WRAM_ADDR[12:0]];
        if (!bus.O_WRAM_WE_L) mem[bus.O_WRAM_ADDR[12:0]] <= bus.O_WRAM_WDATA;
    end
    assign bus.I_WRAM_RDATA = bank_rdata;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        oob;
        logic [15:0] waddr;
    } vec_t;

    // CPU transaction: returns ACK latency (0 = timed out) and what the bank saw
    task automatic cpu_xfer(input logic we, input logic [15:0] addr,
                            input logic [7:0] wdata,
                            output int lat, output logic [7:0] rdata,
                            output logic oob, output int re_n, output int we_n,
                            output logic [15:0] seen_addr,
                            output logic [7:0] seen_wdata,
                            output logic post_ack);
        lat = 0; rdata = 8'h00; oob = 1'b0; re_n = 0; we_n = 0;
        seen_addr = 16'h0000; seen_wdata = 8'h00; post_ack = 1'b0;
        @(posedge clk); #1;
        bus.I_CPU_REQ = 1'b1; bus.I_CPU_WE = we;
        bus.I_CPU_ADDR = addr; bus.I_CPU_WDATA = wdata;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (!bus.O_WRAM_RE_L) begin re_n++; seen_addr = bus.O_WRAM_ADDR; end
            if (!bus.O_WRAM_WE_L) begin
                we_n++; seen_addr = bus.O_WRAM_ADDR;
                seen_wdata = bus.O_WRAM_WDATA;
            end
            if (bus.O_CPU_ACK) begin
                lat = n; rdata = bus.O_CPU_RDATA; oob = bus.O_OOB_ERR;
                break;
            end
        end
        @(posedge clk); #1;
        bus.I_CPU_REQ = 1'b0;
        @(negedge clk);
        post_ack = bus.O_CPU_ACK | bus.O_OOB_ERR | !bus.O_WRAM_RE_L
                   | !bus.O_WRAM_WE_L;
    endtask

    vec_t vecs [12];
    int lat, re_n, we_n, n_dma, dma_before, got;
    logic [7:0] rd, wd;
    logic oob, post;
    logic [15:0] sa;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0123] = 8'h5A;
        mem[13'h1FFF] = 8'h3C;
        mem[13'h1DFF] = 8'hA5;
        mem[13'h0200] = 8'hD7;
        mem[13'h1000] = 8'hE1;

        vecs[0]  = '{1'b0, 16'hC123, 8'h00, 8'h5A, 1'b0, 16'hC123};
        vecs[1]  = '{1'b1, 16'hE010, 8'h77, 8'h5A, 1'b0, 16'hC010};
        vecs[2]  = '{1'b0, 16'hE010, 8'h00, 8'h77, 1'b0, 16'hC010};
        vecs[3]  = '{1'b0, 16'hDFFF, 8'h00, 8'h3C, 1'b0, 16'hDFFF};
        vecs[4]  = '{1'b0, 16'hFDFF, 8'h00, 8'hA5, 1'b0, 16'hDDFF};
        vecs[5]  = '{1'b0, 16'hFE00, 8'h00, 8'hFF, 1'b1, 16'h0000};
        vecs[6]  = '{1'b1, 16'hC000, 8'h11, 8'hFF, 1'b0, 16'hC000};
        vecs[7]  = '{1'b0, 16'hC000, 8'h00, 8'h11, 1'b0, 16'hC000};
        vecs[8]  = '{1'b1, 16'hFF80, 8'h99, 8'h11, 1'b1, 16'h0000};
        vecs[9]  = '{1'b0, 16'hBFFF, 8'h00, 8'hFF, 1'b1, 16'h0000};
        vecs[10] = '{1'b0, 16'hE000, 8'h00, 8'h11, 1'b0, 16'hC000};
        vecs[11] = '{1'b0, 16'hFF80, 8'h00, 8'hFF, 1'b1, 16'h0000};

        bus.I_CPU_REQ = 0; bus.I_CPU_WE = 0;
        bus.I_CPU_ADDR = 16'h0; bus.I_CPU_WDATA = 8'h0;
        bus.I_DMA_REQ = 0; bus.I_DMA_WE = 0;
        bus.I_DMA_ADDR = 16'hC200; bus.I_DMA_WDATA = 8'h0;
        bus.I_DMA_LOCK = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ack", bus.O_CPU_ACK, 0);
        chk("rst_dma_ack", bus.O_DMA_ACK, 0);
        chk("rst_cpu_rdata", bus.O_CPU_RDATA, 8'hFF);
        chk("rst_dma_rdata", bus.O_DMA_RDATA, 8'hFF);
        chk("rst_strobes", {bus.O_WRAM_WE_L, bus.O_WRAM_RE_L}, 2'b11);
        chk("rst_addr", bus.O_WRAM_ADDR, 16'h0000);
        chk("rst_wdata", bus.O_WRAM_WDATA, 8'h00);
        chk("rst_grant_oob", {bus.O_GRANT_DMA, bus.O_OOB_ERR}, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cpu_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                     lat, rd, oob, re_n, we_n, sa, wd, post);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_oob", i), oob, vecs[i].oob);
            chk($sformatf("v%0d_re_count", i), re_n,
                (!vecs[i].we && !vecs[i].oob) ? 1 : 0);
            chk($sformatf("v%0d_we_count", i), we_n,
                (vecs[i].we && !vecs[i].oob) ? 1 : 0);
            if (!vecs[i].oob)
                chk($sformatf("v%0d_bank_addr", i), sa, vecs[i].waddr);
            if (vecs[i].we && !vecs[i].oob)
                chk($sformatf("v%0d_bank_wdata", i), wd, vecs[i].wdata);
            chk($sformatf("v%0d_no_reissue", i), post, 0);
        end

        // CPU vs streaming DMA, unlocked: two rounds of 4 DMA then 1 CPU
        @(posedge clk); #1;
        bus.I_CPU_WE = 0; bus.I_CPU_ADDR = 16'hD000;
        bus.I_CPU_REQ = 1; bus.I_DMA_REQ = 1;
        for (int r = 0; r < 2; r++) begin
            n_dma = 0; dma_before = -1;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (bus.O_DMA_ACK) begin
                    n_dma++;
                    if (n_dma == 1 && r == 0) begin
                        chk("dma_rdata", bus.O_DMA_RDATA, 8'hD7);
                        chk("dma_grant_flag", bus.O_GRANT_DMA, 1);
                    end
                end
                if (bus.O_CPU_ACK) begin
                    dma_before = n_dma;
                    if (r == 0) begin
                        chk("cpu_rdata_vs_dma", bus.O_CPU_RDATA, 8'hE1);
                        chk("cpu_grant_flag", bus.O_GRANT_DMA, 0);
                    end
                    @(posedge clk); #1 bus.I_CPU_REQ = 0;
                    break;
                end
            end
            chk($sformatf("run%0d_dma_before_cpu", r), dma_before, 4);
            got = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.O_DMA_ACK) begin got = 1; break; end
            end
            chk($sformatf("run%0d_dma_resumes", r), got, 1);
            @(posedge clk); #1;
            if (r == 0) bus.I_CPU_REQ = 1;
            else bus.I_DMA_REQ = 0;
        end
        repeat (4) @(posedge clk);

        // Locked DMA burst: CPU must wait for all 160 accesses
        #1 bus.I_DMA_LOCK = 1; bus.I_DMA_REQ = 1; bus.I_CPU_REQ = 1;
        n_dma = 0; got = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.O_CPU_ACK) got++;
            if (bus.O_DMA_ACK) n_dma++;
            if (n_dma == 160) break;
        end
        chk("lock_dma_acks", n_dma, 160);
        chk("lock_cpu_acks", got, 0);
        @(posedge clk); #1 bus.I_DMA_LOCK = 0; bus.I_DMA_REQ = 0;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.O_CPU_ACK) begin lat = n; break; end
        end
        chk("unlock_cpu_ack_within_4", (lat >= 1 && lat <= 4), 1);
        @(posedge clk); #1 bus.I_CPU_REQ = 0;
        repeat (3) @(posedge clk);

        // Reset during ISSUE of a write aborts it
        #1 bus.I_CPU_REQ = 1; bus.I_CPU_WE = 1;
        bus.I_CPU_ADDR = 16'hC050; bus.I_CPU_WDATA = 8'h42;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_low_in_issue", bus.O_WRAM_WE_L, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we_high_now", bus.O_WRAM_WE_L, 1);
        bus.I_CPU_REQ = 0;
        got = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.O_CPU_ACK) got++;
        end
        chk("abort_no_ack", got, 0);
        chk("abort_no_write", mem[13'h0050], 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        cpu_xfer(1'b0, 16'hC123, 8'h00, lat, rd, oob, re_n, we_n, sa, wd, post);
        chk("post_reset_latency", lat, 3);
        chk("post_reset_rdata", rd, 8'h5A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
